// File: rtl/lfsr_period_monitor_pkg.sv
// Shared types for the LFSR period monitor: FSM state encoding and the default
// LFSR width used by both the generator and this checker.
package lfsr_period_monitor_pkg;

    localparam int LFSR_WIDTH = 64;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        RUN     = 2'd2,
        DONE    = 2'd3
    } mon_state_t;

endpackage

// File: rtl/lfsr_period_monitor_if.sv
// Sample stream in, measurement results out. The master side drives the LFSR
// samples and start pulses; the slave side is the monitor.
interface lfsr_period_monitor_if #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 64
);
    logic             start;
    logic             in_valid;
    logic [WIDTH-1:0] lfsr_q;
    logic             busy;
    logic             done;
    logic             repeated;
    logic             maximal;
    logic             lockout;
    logic             timeout;
    logic [CNT_W-1:0] period;

    modport master (
        output start, in_valid, lfsr_q,
        input  busy, done, repeated, maximal, lockout, timeout, period
    );

    modport slave (
        input  start, in_valid, lfsr_q,
        output busy, done, repeated, maximal, lockout, timeout, period
    );
endinterface

// File: rtl/lfsr_mon_counter.sv
// Sample counter for the period monitor. term_o flags that the next increment
// reaches MAX_ITER, so the FSM can decide on the same sample that hits the limit.
module lfsr_mon_counter #(
    parameter int               CNT_W    = 64,
    parameter logic [CNT_W-1:0] MAX_ITER = CNT_W'(2**20)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic [CNT_W-1:0] cnt_inc_o,
    output logic             term_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign cnt_inc_o = cnt_q + CNT_W'(1);
    assign term_o    = (cnt_inc_o == MAX_ITER);
    assign cnt_o     = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_inc_o;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/lfsr_period_monitor.sv
// Measures the recurrence period of an LFSR state stream: captures a reference
// sample, counts accepted samples, and ends on lockout, repeat or timeout.
module lfsr_period_monitor
    import lfsr_period_monitor_pkg::*;
#(
    parameter int               WIDTH      = LFSR_WIDTH,
    parameter int               CNT_W      = 64,
    parameter logic [WIDTH-1:0] LOCK_VAL   = '0,
    parameter logic [CNT_W-1:0] EXP_PERIOD = CNT_W'({WIDTH{1'b1}}),
    parameter logic [CNT_W-1:0] MAX_ITER   = CNT_W'(2**20)
) (
    input logic                  clk,
    input logic                  reset,
    lfsr_period_monitor_if.slave mon
);

    mon_state_t       state_q, state_d;
    logic [WIDTH-1:0] ref_q, ref_d;
    logic             repeated_q, repeated_d;
    logic             maximal_q, maximal_d;
    logic             lockout_q, lockout_d;
    logic             timeout_q, timeout_d;
    logic             busy_q, done_q;
    logic             cnt_clr, cnt_en, cnt_term;
    logic [CNT_W-1:0] cnt, cnt_inc;

    lfsr_mon_counter #(
        .CNT_W    (CNT_W),
        .MAX_ITER (MAX_ITER)
    ) u_counter (
        .clk       (clk),
        .reset     (reset),
        .clr_i     (cnt_clr),
        .en_i      (cnt_en),
        .cnt_o     (cnt),
        .cnt_inc_o (cnt_inc),
        .term_o    (cnt_term)
    );

    always_comb begin
        state_d    = state_q;
        ref_d      = ref_q;
        repeated_d = repeated_q;
        maximal_d  = maximal_q;
        lockout_d  = lockout_q;
        timeout_d  = timeout_q;
        cnt_clr    = 1'b0;
        cnt_en     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (mon.start) begin
                    cnt_clr = 1'b1;
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                if (mon.in_valid) begin
                    ref_d   = mon.lfsr_q;
                    cnt_clr = 1'b1;
                    if (mon.lfsr_q == LOCK_VAL) begin
                        lockout_d = 1'b1;
                        state_d   = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (mon.in_valid) begin
                    cnt_en = 1'b1;
                    // Lockout outranks repeat, which outranks timeout: one flag only.
                    if (mon.lfsr_q == LOCK_VAL) begin
                        lockout_d = 1'b1;
                        state_d   = DONE;
                    end else if (mon.lfsr_q == ref_q) begin
                        repeated_d = 1'b1;
                        maximal_d  = (cnt_inc == EXP_PERIOD);
                        state_d    = DONE;
                    end else if (cnt_term) begin
                        timeout_d = 1'b1;
                        state_d   = DONE;
                    end
                end
            end
            DONE: begin
                if (mon.start) begin
                    repeated_d = 1'b0;
                    maximal_d  = 1'b0;
                    lockout_d  = 1'b0;
                    timeout_d  = 1'b0;
                    cnt_clr    = 1'b1;
                    state_d    = CAPTURE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            ref_q      <= '0;
            repeated_q <= 1'b0;
            maximal_q  <= 1'b0;
            lockout_q  <= 1'b0;
            timeout_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ref_q      <= ref_d;
            repeated_q <= repeated_d;
            maximal_q  <= maximal_d;
            lockout_q  <= lockout_d;
            timeout_q  <= timeout_d;
            busy_q     <= (state_d == CAPTURE) || (state_d == RUN);
            done_q     <= (state_d == DONE);
        end
    end

    assign mon.busy     = busy_q;
    assign mon.done     = done_q;
    assign mon.repeated = repeated_q;
    assign mon.maximal  = maximal_q;
    assign mon.lockout  = lockout_q;
    assign mon.timeout  = timeout_q;
    assign mon.period   = cnt;

endmodule

// File: tb/tb_lfsr_period_monitor.sv
// Directed and randomized checks of lfsr_period_monitor (WIDTH=4, CNT_W=8, MAX_ITER=20)
// against a stream-level reference model.
module tb_lfsr_period_monitor;

    localparam int W  = 4;
    localparam int CW = 8;
    localparam int MI = 20;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lfsr_period_monitor_if #(.WIDTH(W), .CNT_W(CW)) mif ();

    lfsr_period_monitor #(
        .WIDTH    (W),
        .CNT_W    (CW),
        .LOCK_VAL (4'h0),
        .MAX_ITER (8'd20)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .mon   (mif)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [W-1:0] stim[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // x^4+x^3+1, XOR taps, shift left with feedback into bit 0
    function automatic logic [W-1:0] lfsr_next(input logic [W-1:0] s);
        return {s[2:0], s[3] ^ s[2]};
    endfunction

    task automatic gen_lfsr(input logic [W-1:0] seed, input int n);
        logic [W-1:0] s = seed;
        stim.delete();
        for (int i = 0; i < n; i++) begin
            stim.push_back(s);
            s = lfsr_next(s);
        end
    endtask

    // Reference: first sample is the reference; walk the rest and stop at the
    // first lockout, recurrence or iteration limit.
    function automatic void model(output int cons, output int per, output bit rep,
                                  output bit mx, output bit lk, output bit to);
        logic [W-1:0] r = stim[0];
        cons = 0; per = 0; rep = 0; mx = 0; lk = 0; to = 0;
        if (r == 4'h0) begin
            lk = 1; cons = 1; per = 0;
            return;
        end
        for (int k = 1; k < stim.size(); k++) begin
            if (stim[k] == 4'h0) lk = 1;
            else if (stim[k] == r) begin rep = 1; mx = (k == 15); end
            else if (k == MI) to = 1;
            if (lk || rep || to) begin
                cons = k + 1; per = k;
                return;
            end
        end
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, "_busy"}, mif.busy, 0);
        chk({tag, "_done"}, mif.done, 0);
        chk({tag, "_rep"}, mif.repeated, 0);
        chk({tag, "_max"}, mif.maximal, 0);
        chk({tag, "_lock"}, mif.lockout, 0);
        chk({tag, "_tmo"}, mif.timeout, 0);
        chk({tag, "_per"}, mif.period, 0);
    endtask

    // gap_mode: 0 none, 1 one idle cycle before every sample, 2 random 0..3 idle cycles
    task automatic run_meas(input string name, input int gap_mode);
        int e_cons, e_per, idx, ngap;
        bit e_rep, e_max, e_lck, e_to, seen;
        logic [CW-1:0] per_hold;
        model(e_cons, e_per, e_rep, e_max, e_lck, e_to);
        idx = 0; seen = 0;
        mif.start = 1'b1;
        @(negedge clk);
        mif.start = 1'b0;
        mif.in_valid = 1'b0;
        chk({name, "_busy_start"}, mif.busy, 1);
        chk({name, "_done_clr"}, mif.done, 0);
        chk({name, "_per_clr"}, mif.period, 0);
        while (idx < stim.size() && !seen) begin
            ngap = (gap_mode == 1) ? 1 : (gap_mode == 2) ? $urandom_range(0, 3) : 0;
            repeat (ngap) begin
                mif.in_valid = 1'b0;
                mif.lfsr_q = W'($urandom);
                @(negedge clk);
            end
            mif.in_valid = 1'b1;
            mif.lfsr_q = stim[idx];
            @(negedge clk);
            mif.in_valid = 1'b0;
            idx++;
            if (mif.done) seen = 1;
            else if (idx > 1) chk({name, "_live_per"}, mif.period, idx - 1);
        end
        chk({name, "_done"}, seen, 1);
        chk({name, "_samples"}, idx, e_cons);
        chk({name, "_busy_end"}, mif.busy, 0);
        chk({name, "_rep"}, mif.repeated, e_rep);
        chk({name, "_max"}, mif.maximal, e_max);
        chk({name, "_lock"}, mif.lockout, e_lck);
        chk({name, "_tmo"}, mif.timeout, e_to);
        chk({name, "_per"}, mif.period, e_per);
        per_hold = mif.period;
        repeat (3) begin
            mif.in_valid = 1'($urandom);
            mif.lfsr_q = W'($urandom);
            @(negedge clk);
        end
        mif.in_valid = 1'b0;
        chk({name, "_hold_done"}, mif.done, 1);
        chk({name, "_hold_per"}, mif.period, per_hold);
    endtask

    initial begin
        reset = 1'b1;
        mif.start = 1'b0;
        mif.in_valid = 1'b0;
        mif.lfsr_q = '0;
        repeat (2) @(negedge clk);
        check_idle("reset");
        reset = 1'b0;

        // IDLE ignores samples, even the lockout value
        mif.in_valid = 1'b1;
        mif.lfsr_q = 4'h0;
        repeat (3) @(negedge clk);
        check_idle("idle_ign");

        stim = '{4'h0};
        run_meas("t2_lock", 0);

        gen_lfsr(4'h1, 16);
        run_meas("t1_max", 0);

        stim.delete();
        for (int i = 0; i < 12; i++) stim.push_back(W'(i % 6 + 1));
        run_meas("t3_p6", 0);

        // Never returns to the reference (1) and never hits 0: ends on the limit
        stim.delete();
        stim.push_back(4'h1);
        for (int i = 0; i < 24; i++) stim.push_back(W'(i % 14 + 2));
        run_meas("t4_tmo", 0);

        gen_lfsr(4'h1, 16);
        run_meas("t5_gap", 1);

        for (int n = 0; n < 6; n++) begin
            gen_lfsr(W'($urandom_range(1, 15)), 16);
            run_meas("rnd_lfsr", 2);
        end
        for (int n = 0; n < 8; n++) begin
            stim.delete();
            for (int i = 0; i < 25; i++) stim.push_back(W'($urandom_range(0, 15)));
            run_meas("rnd_val", 2);
        end

        // start during RUN is ignored; reset mid-RUN clears everything
        gen_lfsr(4'h3, 16);
        mif.start = 1'b1;
        @(negedge clk);
        mif.start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            mif.in_valid = 1'b1;
            mif.lfsr_q = stim[k];
            mif.start = (k == 4);
            @(negedge clk);
            chk("t6_per", mif.period, k);
            chk("t6_busy", mif.busy, 1);
        end
        mif.start = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        check_idle("t6_reset");
        reset = 1'b0;
        mif.start = 1'b0;
        mif.in_valid = 1'b0;
        @(negedge clk);

        gen_lfsr(4'h9, 16);
        run_meas("t6_recover", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
